switch_egress_queue: RTL and testbench
======================================

# switch_egress_queue

Store-and-forward output queue placed on each egress port of the 4-port switch, directly downstream of `switch_port`, one instance per port (0-3). It accepts a byte stream framed by start/end markers and buffers whole packets. It releases a packet to the port side only after its last byte has been stored. When a packet cannot fit, the block drops the whole packet by rewinding the write pointer, and counts the drop.

## Interface
- `DATA_W`, 8, payload byte width
- `DEPTH`, 64, buffer entries; power of two, at least 4
- `PORT_ID`, 0, egress port number (0-3); informational only, no functional effect

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  fabric beat valid
- `in_data`  in  DATA_W  fabric byte
- `in_sop`  in  1  first byte of packet
- `in_eop`  in  1  last byte of packet; may coincide with `in_sop`
- `in_ready`  out  1  registered; 0 during reset, 1 from the first cycle after reset
- `out_valid`  out  1  committed byte available
- `out_data`  out  DATA_W  head byte
- `out_sop`, `out_eop`  out  1 each  framing of head byte
- `out_ready`  in  1  port-side accept
- `pkt_count`  out  $clog2(DEPTH)+1  committed packets held
- `level`  out  $clog2(DEPTH)+1  entries occupied, partial packet included
- `drop_count`  out  16  dropped packets; saturates at 16'hFFFF

## Operation
- Storage: DEPTH entries of {sop, eop, data}.
- Pointers are $clog2(DEPTH)+1 bits wide, so they wrap modulo 2*DEPTH:
  - `wr_ptr` is speculative.
  - `commit_ptr` marks the end of the last complete packet.
  - `rd_ptr` is the read pointer.
- Free space = DEPTH - (`wr_ptr` - `rd_ptr`). It is evaluated on pre-edge values, so a read in the same cycle does not free space until the next cycle.
- A beat is accepted when `in_valid` and `in_ready` are both high.
- Input FSM:
  - IDLE:
    - Accepted beat with sop and space > 0: write the byte. If eop, commit and stay in IDLE; otherwise go to RECV.
    - Accepted beat with sop and space = 0: increment `drop_count`; go to DROP, or stay in IDLE if eop.
    - Beat without sop: ignore, no count.
  - RECV:
    - Beat without sop and space > 0: write the byte; on eop set `commit_ptr` to `wr_ptr`+1, increment `pkt_count`, go to IDLE.
    - Beat without sop and space = 0: set `wr_ptr` to `commit_ptr`, increment `drop_count`; go to IDLE if eop, else DROP.
    - Beat with sop: abort the partial packet (set `wr_ptr` to `commit_ptr`), increment `drop_count`, then treat the beat as in IDLE in the same cycle.
  - DROP:
    - Discard beats until eop, then go to IDLE.
    - A sop beat in DROP is handled as in RECV, with no extra drop count.
- Any packet longer than DEPTH is always dropped.
- Output side:
  - `out_valid` = (`rd_ptr` != `commit_ptr`).
  - `out_data`, `out_sop` and `out_eop` are read combinationally from `mem[rd_ptr]`.
  - `rd_ptr` increments on `out_valid && out_ready`.
- `pkt_count`:
  - +1 on commit.
  - -1 on an output handshake with `out_eop`.
  - Both in the same cycle: unchanged.
- `level` = `wr_ptr` - `rd_ptr`.

## Timing
- Reset (synchronous, overrides all else):
  - All pointers, `pkt_count`, `level` and `drop_count` go to 0.
  - FSM goes to IDLE.
  - `in_ready` = 0 and `out_valid` = 0 in the cycle after the reset edge.
  - Memory contents are not cleared.
  - Reset mid-packet discards both partial and committed data; no drop is counted.
- Commit latency: the eop beat is accepted on edge E and `commit_ptr` updates at E. With an empty queue, `out_valid` and the first byte are presented in the cycle after E.
- Throughput: one byte in and one byte out per cycle, sustained and concurrent.
- Backpressure: while `out_valid && !out_ready`, the `out_*` signals hold stable.
- A committed packet is never partially overwritten. Dropping affects only uncommitted entries.
- Pointer wrap-around is transparent. Full means `wr_ptr` - `rd_ptr` = DEPTH.

## Test plan
- Single 4-byte packet A0..A3 into an empty queue, `out_ready` = 1:
  - `out_valid` rises the cycle after eop is accepted.
  - A0 (sop) .. A3 (eop) leave on 4 consecutive cycles.
  - `pkt_count` goes 0→1→0.
- `out_ready` = 0, then send 1-byte packets (sop = eop = 1) until full:
  - 64 packets commit.
  - The 65th is dropped: `drop_count` = 1, `level` = 64, `pkt_count` = 64.
- `out_ready` = 0, DEPTH = 64, then send a 40-byte packet followed by a 30-byte packet:
  - The second packet overflows at byte 25; `wr_ptr` rewinds to 40.
  - Remaining bytes are discarded; `drop_count` = 1.
  - After draining, only the 40-byte packet has been output.
- Sop mid-packet: 3 bytes of packet B, then a sop beat starting 2-byte packet C:
  - B is discarded and `drop_count` = 1.
  - Output is exactly C0, C1 with correct sop/eop.
- Wrap-around with random `out_ready` (50%): 500 random-length packets of 1-20 bytes:
  - Output byte stream equals input minus dropped packets, in order.
  - `pkt_count` and `level` match the model every cycle.
- Reset asserted for 1 cycle mid-packet with 2 packets committed:
  - Next cycle `out_valid` = 0 and all counters = 0.
  - `in_ready` = 1 one cycle later.
  - A new packet then passes normally.

Source files
------------

// File: rtl/switch_egress_queue.sv
// switch_egress_queue: store-and-forward egress buffer for one switch port.
// Whole packets are buffered and released only once their last byte is stored;
// packets that do not fit are dropped by rewinding the speculative write pointer.
module switch_egress_queue #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned PORT_ID = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Elaboration-time parameter sanity checks
    if (PORT_ID > 3) begin : g_port_id_range
        $error("switch_egress_queue: PORT_ID must be in 0..3");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_pow2
        $error("switch_egress_queue: DEPTH must be a power of two >= 4");
    end

    logic [EW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_commit_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_pkt_count;
    logic [15:0]    r_drop_count;
    logic           r_in_ready;
    state_t         r_state;

    state_t         w_state_nxt;
    logic           w_accept;
    logic [PW-1:0]  w_base;
    logic           w_space;
    logic           w_wr_en;
    logic           w_commit;
    logic           w_rewind;
    logic [1:0]     w_drop_add;
    logic [16:0]    w_drop_sum;
    logic [EW-1:0]  w_head;
    logic           w_rd_fire;
    logic           w_pop_eop;

    assign w_accept = in_valid & r_in_ready;
    // A sop beat always starts at the last commit point (aborting any partial packet)
    assign w_base   = in_sop ? r_commit_ptr : r_wr_ptr;
    assign w_space  = (w_base - r_rd_ptr) != PW'(DEPTH);

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid = (r_rd_ptr != r_commit_ptr);
    assign out_sop   = w_head[EW-1];
    assign out_eop   = w_head[EW-2];
    assign out_data  = w_head[DATA_W-1:0];
    assign w_rd_fire = out_valid & out_ready;
    assign w_pop_eop = w_rd_fire & out_eop;

    assign in_ready   = r_in_ready;
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;
    assign level      = r_wr_ptr - r_rd_ptr;

    assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_add);

    // Input FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (in_sop) begin
                if (in_eop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = w_space ? ST_RECV : ST_DROP;
                end
            end else begin
                case (r_state)
                    ST_RECV: begin
                        if (in_eop) begin
                            w_state_nxt = ST_IDLE;
                        end else if (!w_space) begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        if (in_eop) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    // Input FSM actions: write, commit, rewind and drop accounting
    always_comb begin
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_rewind   = 1'b0;
        w_drop_add = 2'd0;
        if (w_accept) begin
            if (in_sop) begin
                // Aborting a partial packet and overflowing the new one are two drops
                w_rewind   = (r_state != ST_IDLE);
                w_drop_add = 2'((r_state == ST_RECV) ? 1 : 0) + 2'(w_space ? 0 : 1);
                w_wr_en    = w_space;
                w_commit   = w_space & in_eop;
            end else if (r_state == ST_RECV) begin
                if (w_space) begin
                    w_wr_en  = 1'b1;
                    w_commit = in_eop;
                end else begin
                    w_rewind   = 1'b1;
                    w_drop_add = 2'd1;
                end
            end
        end
    end

    // Buffer storage; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_base[AW-1:0]] <= {in_sop, in_eop, in_data};
        end
    end

    // Pointers, counters and input-ready register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            if (w_wr_en) begin
                r_wr_ptr <= w_base + PW'(1);
            end else if (w_rewind) begin
                r_wr_ptr <= r_commit_ptr;
            end
            if (w_commit) begin
                r_commit_ptr <= w_base + PW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_commit && !w_pop_eop) begin
                r_pkt_count <= r_pkt_count + PW'(1);
            end else if (!w_commit && w_pop_eop) begin
                r_pkt_count <= r_pkt_count - PW'(1);
            end
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_switch_egress_queue.sv
// tb_switch_egress_queue: directed and randomized checks of switch_egress_queue
// against a queue-based packet model, with directed expected values per scenario.
module tb_switch_egress_queue;

    localparam int DEPTH = 64;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_ready;
    logic [6:0] pkt_count;
    logic [6:0] level;
    logic [15:0] drop_count;

    switch_egress_queue #(.DATA_W(8), .DEPTH(DEPTH), .PORT_ID(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count),
        .level      (level),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: committed entries, pending partial packet, observed output
    logic [9:0] cq[$];
    logic [9:0] pq[$];
    logic [9:0] outq[$];
    int         m_pkts;
    int         m_drop;
    int         m_st;     // 0 idle, 1 receiving, 2 dropping
    bit         m_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void m_commit();
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
        m_pkts++;
    endfunction

    function automatic void m_add_drop();
        if (m_drop < 16'hFFFF) m_drop++;
    endfunction

    // Advance the model by one clock edge using pre-edge occupancy
    function automatic void m_step(input logic v, input logic s, input logic e,
                                   input logic [7:0] d, input logic rdy);
        bit hs;
        int used;
        logic [9:0] ent;
        hs   = (cq.size() != 0) && rdy;
        used = cq.size() + pq.size();
        if (v && m_rdy) begin
            if (s) begin
                if (m_st == 1) m_add_drop();
                pq.delete();
                used = cq.size();
                if (used < DEPTH) begin
                    pq.push_back({s, e, d});
                    if (e) m_commit();
                    m_st = e ? 0 : 1;
                end else begin
                    m_add_drop();
                    m_st = e ? 0 : 2;
                end
            end else if (m_st == 1) begin
                if (used < DEPTH) begin
                    pq.push_back({s, e, d});
                    if (e) begin
                        m_commit();
                        m_st = 0;
                    end
                end else begin
                    pq.delete();
                    m_add_drop();
                    m_st = e ? 0 : 2;
                end
            end else if (m_st == 2 && e) begin
                m_st = 0;
            end
        end
        if (hs) begin
            ent = cq.pop_front();
            if (ent[8]) m_pkts--;
        end
        m_rdy = 1'b1;
    endfunction

    // One clock cycle: drive inputs, compare DUT with model, advance
    task automatic cyc(input logic v, input logic s, input logic e,
                       input logic [7:0] d, input logic rdy);
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = d;
        out_ready = rdy;
        check("in_ready", 32'(in_ready), 32'(m_rdy));
        check("out_valid", 32'(out_valid), 32'(cq.size() != 0));
        check("level", 32'(level), 32'(cq.size() + pq.size()));
        check("pkt_count", 32'(pkt_count), 32'(m_pkts));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        if (out_valid && cq.size() != 0)
            check("head", 32'({out_sop, out_eop, out_data}), 32'(cq[0]));
        if (out_valid && rdy) outq.push_back({out_sop, out_eop, out_data});
        m_step(v, s, e, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cq.delete();
        pq.delete();
        outq.delete();
        m_pkts = 0;
        m_drop = 0;
        m_st   = 0;
        m_rdy  = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_pkt_count", 32'(pkt_count), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
    endtask

    initial begin
        int len;
        reset = 1'b1;

        // Single 4-byte packet, latency and back-to-back output
        do_reset();
        cyc(0, 0, 0, 8'h00, 1);
        cyc(1, 1, 0, 8'hA0, 1);
        cyc(1, 0, 0, 8'hA1, 1);
        cyc(1, 0, 0, 8'hA2, 1);
        check("t1_no_valid_before_eop", 32'(out_valid), 32'h0);
        check("t1_pkt_before", 32'(pkt_count), 32'h0);
        cyc(1, 0, 1, 8'hA3, 1);
        check("t1_valid_after_eop", 32'(out_valid), 32'h1);
        check("t1_pkt_one", 32'(pkt_count), 32'h1);
        check("t1_head", 32'({out_sop, out_eop, out_data}), 32'h2A0);
        repeat (4) cyc(0, 0, 0, 8'h00, 1);
        check("t1_out_count", 32'(outq.size()), 32'd4);
        if (outq.size() == 4) begin
            check("t1_b0", 32'(outq[0]), 32'h2A0);
            check("t1_b1", 32'(outq[1]), 32'h0A1);
            check("t1_b2", 32'(outq[2]), 32'h0A2);
            check("t1_b3", 32'(outq[3]), 32'h1A3);
        end
        check("t1_pkt_zero", 32'(pkt_count), 32'h0);
        check("t1_empty", 32'(out_valid), 32'h0);

        // Fill with 1-byte packets; the 65th is dropped
        do_reset();
        cyc(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 65; i++) cyc(1, 1, 1, 8'(i), 0);
        check("t2_drop", 32'(drop_count), 32'd1);
        check("t2_level", 32'(level), 32'd64);
        check("t2_pkt", 32'(pkt_count), 32'd64);
        repeat (66) cyc(0, 0, 0, 8'h00, 1);
        check("t2_out_count", 32'(outq.size()), 32'd64);
        if (outq.size() == 64) begin
            check("t2_first", 32'(outq[0]), 32'h300);
            check("t2_last", 32'(outq[63]), 32'h33F);
        end
        check("t2_drained_level", 32'(level), 32'h0);

        // 40-byte packet then a 30-byte packet that overflows at byte 25
        do_reset();
        cyc(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 40; i++) cyc(1, i == 0, i == 39, 8'(i), 0);
        for (int i = 0; i < 24; i++) cyc(1, i == 0, 1'b0, 8'(8'h80 + i), 0);
        check("t3_level_full", 32'(level), 32'd64);
        cyc(1, 0, 0, 8'h98, 0);
        check("t3_rewind_level", 32'(level), 32'd40);
        check("t3_drop_now", 32'(drop_count), 32'd1);
        for (int i = 25; i < 30; i++) cyc(1, 1'b0, i == 29, 8'(8'h80 + i), 0);
        check("t3_drop", 32'(drop_count), 32'd1);
        check("t3_pkt", 32'(pkt_count), 32'd1);
        check("t3_level", 32'(level), 32'd40);
        repeat (45) cyc(0, 0, 0, 8'h00, 1);
        check("t3_out_count", 32'(outq.size()), 32'd40);
        if (outq.size() == 40) begin
            check("t3_first", 32'(outq[0]), 32'h200);
            check("t3_last", 32'(outq[39]), 32'h127);
        end

        // sop in the middle of packet B starts packet C
        do_reset();
        cyc(0, 0, 0, 8'h00, 1);
        cyc(1, 1, 0, 8'hB0, 1);
        cyc(1, 0, 0, 8'hB1, 1);
        cyc(1, 0, 0, 8'hB2, 1);
        cyc(1, 1, 0, 8'hC0, 1);
        check("t4_drop", 32'(drop_count), 32'd1);
        cyc(1, 0, 1, 8'hC1, 1);
        repeat (4) cyc(0, 0, 0, 8'h00, 1);
        check("t4_out_count", 32'(outq.size()), 32'd2);
        if (outq.size() == 2) begin
            check("t4_c0", 32'(outq[0]), 32'h2C0);
            check("t4_c1", 32'(outq[1]), 32'h1C1);
        end

        // Random traffic with random backpressure and pointer wrap
        do_reset();
        cyc(0, 0, 0, 8'h00, 0);
        for (int p = 0; p < 500; p++) begin
            len = $urandom_range(20, 1);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(7, 0) == 0) cyc(0, 0, 0, 8'h00, 1'($urandom_range(1, 0)));
                cyc(1, b == 0, b == len - 1, 8'($urandom), 1'($urandom_range(1, 0)));
            end
        end
        repeat (80) cyc(0, 0, 0, 8'h00, 1);
        check("t5_drained_level", 32'(level), 32'h0);
        check("t5_drained_pkt", 32'(pkt_count), 32'h0);

        // Reset mid-packet with two packets committed
        do_reset();
        cyc(0, 0, 0, 8'h00, 0);
        cyc(1, 1, 0, 8'h11, 0);
        cyc(1, 0, 1, 8'h12, 0);
        cyc(1, 1, 0, 8'h21, 0);
        cyc(1, 0, 1, 8'h22, 0);
        cyc(1, 1, 0, 8'h31, 0);
        check("t6_pkt_before", 32'(pkt_count), 32'd2);
        check("t6_level_before", 32'(level), 32'd5);
        do_reset();
        cyc(0, 0, 0, 8'h00, 1);
        check("t6_in_ready", 32'(in_ready), 32'h1);
        cyc(1, 1, 0, 8'h41, 1);
        cyc(1, 0, 0, 8'h42, 1);
        cyc(1, 0, 1, 8'h43, 1);
        repeat (5) cyc(0, 0, 0, 8'h00, 1);
        check("t6_out_count", 32'(outq.size()), 32'd3);
        if (outq.size() == 3) begin
            check("t6_b0", 32'(outq[0]), 32'h241);
            check("t6_b2", 32'(outq[2]), 32'h143);
        end
        check("t6_drop", 32'(drop_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
